cnu_sched: RTL and testbench
============================

CNU_SCHED -- requirements
Module: cnu_sched

Interface
REQ-001 SHALL have parameter N_CHK, default 16, number of check-node rows per iteration (>=2).
REQ-002 SHALL have parameter ROW_W, default 4, row address width; 2^ROW_W >= N_CHK.
REQ-003 SHALL have parameter CNU_LAT, default 3, cycles from CNU input valid to registered CNU output (>=1).
REQ-004 SHALL have parameter ITER_W, default 4, iteration counter width.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  single-cycle request to begin decoding a frame.
REQ-008 max_iter  input  ITER_W  iteration limit, sampled when start is accepted.
REQ-009 hold  input  1  issue stall request (message memory busy).
REQ-010 syn_ok  input  1  parity-check satisfied flag, sampled in CHECK state.
REQ-011 rd_en  output  1  read strobe, q message memory.
REQ-012 rd_addr  output  ROW_W  row read address.
REQ-013 cnu_vld  output  1  CNU input valid; rd_en delayed 1 cycle (memory read latency).
REQ-014 wr_en  output  1  write strobe, r message memory.
REQ-015 wr_addr  output  ROW_W  row write address.
REQ-016 iter  output  ITER_W  current iteration, 0-based.
REQ-017 busy  output  1  high from start acceptance until done.
REQ-018 done  output  1  one-cycle completion pulse.
REQ-019 conv  output  1  converged flag, valid with done, held until next start.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, DRAIN, CHECK, FIN.
REQ-021 IDLE: start=1 -> ISSUE; latch max_iter (0 treated as 1); iter<=0; row counter<=0; busy<=1; conv<=0.
REQ-022 start while busy SHALL be ignored.
REQ-023 ISSUE: hold=0 -> rd_en=1, rd_addr=row counter, counter increments; hold=1 -> rd_en=0, counter holds (bubble).
REQ-024 ISSUE: issue of row N_CHK-1 -> DRAIN next cycle; counter wraps to 0.
REQ-025 rd_en/rd_addr SHALL be combinational from state, counter and hold.
REQ-026 Pipeline: a valid/address shift register of depth 1+CNU_LAT carries each issue; wr_en/wr_addr SHALL equal rd_en/rd_addr delayed exactly 1+CNU_LAT cycles; bubbles propagate unchanged.
REQ-027 cnu_vld SHALL equal rd_en delayed exactly 1 cycle.
REQ-028 hold SHALL NOT stall the pipeline; in-flight rows complete regardless of hold.
REQ-029 DRAIN: hold ignored, no issue; -> CHECK in the cycle after wr_en for row N_CHK-1 (pipeline empty).
REQ-030 CHECK (one cycle): syn_ok=1 -> FIN, conv<=1; else iter+1 == max_iter -> FIN, conv<=0; else iter<=iter+1, -> ISSUE.
REQ-031 FIN: done=1 for one cycle, busy<=0, -> IDLE; iter and conv SHALL hold their values until next accepted start.
REQ-032 A new frame SHALL NOT issue until previous iteration fully drained (no row overlap between iterations).
REQ-033 Each iteration SHALL issue every row 0..N_CHK-1 exactly once, in ascending order.

Reset
REQ-034 rst=1 SHALL force IDLE, clear pipeline shift register, row counter, iter, busy, done, conv, and all registered outputs to 0 immediately.
REQ-035 rst asserted mid-operation SHALL discard in-flight rows: no wr_en after rst deasserts until a new start.
REQ-036 First start SHALL be accepted on the first rising edge with rst low.

Verification (N_CHK=4, CNU_LAT=3)
REQ-037 start, max_iter=1, hold=0, syn_ok=0 -> rd_en cycles 1-4 addr 0,1,2,3; wr_en cycles 5-8 addr 0..3; CHECK cycle 9; done cycle 10, conv=0, iter=0.
REQ-038 hold=1 during second issue cycle -> rd_addr sequence 0,-,1,2,3; wr_en shows identical bubble 4 cycles later; no row skipped or duplicated.
REQ-039 max_iter=3, syn_ok=0 -> exactly 12 rd_en and 12 wr_en pulses; iter 0,1,2; done once; conv=0.
REQ-040 max_iter=5, syn_ok=1 at first CHECK -> done after iteration 0, conv=1, iter=0; no further rd_en.
REQ-041 rst pulse while rows 2,3 in flight -> no wr_en afterwards, busy=0; new start restarts at addr 0, iter=0.
REQ-042 start asserted while busy, and max_iter=0 -> second start ignored; max_iter=0 frame runs one iteration.

Source files
------------

// File: rtl/cnu_sched_if.sv
// Check-node scheduler bus: frame control, memory strobes, status.
// master = scheduler side, slave = decoder datapath/controller side.
interface cnu_sched_if #(
  parameter int ROW_W  = 4,
  parameter int ITER_W = 4
);
  logic              start;
  logic [ITER_W-1:0] max_iter;
  logic              hold;
  logic              syn_ok;
  logic              rd_en;
  logic [ROW_W-1:0]  rd_addr;
  logic              cnu_vld;
  logic              wr_en;
  logic [ROW_W-1:0]  wr_addr;
  logic [ITER_W-1:0] iter;
  logic              busy;
  logic              done;
  logic              conv;

  modport master (
    input  start, max_iter, hold, syn_ok,
    output rd_en, rd_addr, cnu_vld, wr_en, wr_addr,
    output iter, busy, done, conv
  );

  modport slave (
    output start, max_iter, hold, syn_ok,
    input  rd_en, rd_addr, cnu_vld, wr_en, wr_addr,
    input  iter, busy, done, conv
  );
endinterface

// File: rtl/cnu_sched.sv
// Layered LDPC check-node row scheduler: issues rows, tracks the
// CNU pipeline, and runs the iterate / syndrome-check loop.
module cnu_sched #(
  parameter int N_CHK   = 16,
  parameter int ROW_W   = 4,
  parameter int CNU_LAT = 3,
  parameter int ITER_W  = 4
) (
  input logic         clk,
  input logic         rst,
  cnu_sched_if.master bus
);
  localparam int D = 1 + CNU_LAT;
  localparam logic [ROW_W-1:0] LAST = ROW_W'(N_CHK - 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, DRAIN, CHECK, FIN
  } state_t;

  state_t state_q, state_d;

  logic [ROW_W-1:0]  row_q;
  logic [ITER_W-1:0] iter_q;
  logic [ITER_W-1:0] max_q;
  logic [ITER_W-1:0] iter_nx;
  logic              busy_q;
  logic              conv_q;
  logic [D-1:0]      vld_sr;
  logic [ROW_W-1:0]  addr_sr [D];
  logic              rd_en;
  logic [ROW_W-1:0]  rd_addr;
  logic              done;
  logic              last_wr;

  assign iter_nx = iter_q + ITER_W'(1);
  assign last_wr = vld_sr[D-1] && (addr_sr[D-1] == LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and issue strobes
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    rd_addr = row_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE:  if (bus.start) state_d = ISSUE;
      ISSUE: begin
        if (!bus.hold) begin
          rd_en = 1'b1;
          if (row_q == LAST) state_d = DRAIN;
        end
      end
      DRAIN: if (last_wr) state_d = CHECK;
      CHECK: begin
        if (bus.syn_ok || iter_nx == max_q) state_d = FIN;
        else                                state_d = ISSUE;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame bookkeeping: row counter, iteration, limit, flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q  <= '0;
      iter_q <= '0;
      max_q  <= '0;
      busy_q <= 1'b0;
      conv_q <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.start) begin
        max_q  <= (bus.max_iter == '0) ? ITER_W'(1) : bus.max_iter;
        iter_q <= '0;
        row_q  <= '0;
        busy_q <= 1'b1;
        conv_q <= 1'b0;
      end
      if (rd_en)
        row_q <= (row_q == LAST) ? '0 : row_q + ROW_W'(1);
      if (state_q == CHECK) begin
        if (bus.syn_ok)            conv_q <= 1'b1;
        else if (iter_nx != max_q) iter_q <= iter_nx;
      end
      if (state_q == FIN) busy_q <= 1'b0;
    end
  end

  // Read-latency + CNU pipeline tracker; never stalled by hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr <= '0;
      for (int i = 0; i < D; i++) addr_sr[i] <= '0;
    end else begin
      vld_sr     <= {vld_sr[D-2:0], rd_en};
      addr_sr[0] <= rd_addr;
      for (int i = 1; i < D; i++) addr_sr[i] <= addr_sr[i-1];
    end
  end

  assign bus.rd_en   = rd_en;
  assign bus.rd_addr = rd_addr;
  assign bus.cnu_vld = vld_sr[0];
  assign bus.wr_en   = vld_sr[D-1];
  assign bus.wr_addr = addr_sr[D-1];
  assign bus.iter    = iter_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done;
  assign bus.conv    = conv_q;
endmodule

// File: tb/tb_cnu_sched.sv
// Scoreboard bench for cnu_sched (N_CHK=4, CNU_LAT=3): stimulus
// queues expected row/done events, a negedge monitor consumes them.
module tb_cnu_sched;
  localparam int N   = 4;
  localparam int RW  = 2;
  localparam int LAT = 3;
  localparam int IW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cnu_sched_if #(.ROW_W(RW), .ITER_W(IW)) bus ();

  cnu_sched #(
    .N_CHK(N), .ROW_W(RW), .CNU_LAT(LAT), .ITER_W(IW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int cyc;
    int addr;
    int it;
  } ev_t;

  typedef struct {
    int cyc;
    int it;
    int cv;
  } dn_t;

  ev_t rdq[$];
  ev_t wrq[$];
  dn_t dnq[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int b;
  logic prv = 1'b0;
  ev_t e;
  dn_t d;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected rows/done for a frame; bub=1 adds a bubble after row 0
  function automatic void push(int bs, int n, int bub, int cv, int dit);
    int c;
    for (int k = 0; k < n; k++)
      for (int r = 0; r < N; r++) begin
        c = bs + 1 + 9 * k + r + ((bub != 0 && (k > 0 || r >= 1)) ? 1 : 0);
        rdq.push_back('{c, r, k});
        wrq.push_back('{c + 4, r, k});
      end
    dnq.push_back('{bs + 9 * n + 1 + bub, dit, cv});
  endfunction

  task automatic wait_done(int lim);
    int n;
    n = 0;
    while (!bus.done && n < lim) begin
      tick();
      n++;
    end
    checks++;
    if (!bus.done) begin
      errors++;
      $display("FAIL done_timeout actual 0 required 1");
    end
    repeat (3) tick();
  endtask

  task automatic idle_chk(int it, int cv);
    chk("idle_busy", int'(bus.busy), 0);
    chk("idle_iter", int'(bus.iter), it);
    chk("idle_conv", int'(bus.conv), cv);
    chk("idle_wr", int'(bus.wr_en), 0);
  endtask

  // Monitor: consume expected events whenever the DUT presents one
  always @(negedge clk) begin
    if (!rst && (prv || bus.cnu_vld))
      chk("cnu_vld", int'(bus.cnu_vld), int'(prv));
    prv = bus.rd_en;
    if (bus.rd_en) begin
      if (rdq.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexp actual addr %0d at %0d required none",
                 bus.rd_addr, cyc);
      end else begin
        e = rdq.pop_front();
        chk("rd_cyc", cyc, e.cyc);
        chk("rd_addr", int'(bus.rd_addr), e.addr);
        chk("rd_iter", int'(bus.iter), e.it);
      end
    end
    if (bus.wr_en) begin
      if (wrq.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_unexp actual addr %0d at %0d required none",
                 bus.wr_addr, cyc);
      end else begin
        e = wrq.pop_front();
        chk("wr_cyc", cyc, e.cyc);
        chk("wr_addr", int'(bus.wr_addr), e.addr);
        chk("wr_iter", int'(bus.iter), e.it);
      end
    end
    if (bus.done) begin
      if (dnq.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexp actual 1 at %0d required 0", cyc);
      end else begin
        d = dnq.pop_front();
        chk("done_cyc", cyc, d.cyc);
        chk("done_iter", int'(bus.iter), d.it);
        chk("done_conv", int'(bus.conv), d.cv);
      end
    end
  end

  initial begin
    bus.start    = 1'b0;
    bus.max_iter = '0;
    bus.hold     = 1'b0;
    bus.syn_ok   = 1'b0;
    repeat (2) tick();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_rd", int'(bus.rd_en), 0);
    chk("rst_wr", int'(bus.wr_en), 0);
    chk("rst_vld", int'(bus.cnu_vld), 0);
    chk("rst_iter", int'(bus.iter), 0);
    chk("rst_conv", int'(bus.conv), 0);

    // single iteration, start on first edge with rst low
    b = cyc;
    push(b, 1, 0, 0, 0);
    rst = 1'b0;
    bus.max_iter = 4'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("busy_on", int'(bus.busy), 1);
    wait_done(100);
    idle_chk(0, 0);

    // hold bubble in second issue cycle
    b = cyc;
    push(b, 1, 1, 0, 0);
    bus.max_iter = 4'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.hold = 1'b1;
    tick();
    bus.hold = 1'b0;
    wait_done(100);
    idle_chk(0, 0);

    // three iterations, never converged; hold in drain ignored
    b = cyc;
    push(b, 3, 0, 0, 2);
    bus.max_iter = 4'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    bus.hold = 1'b1;
    repeat (2) tick();
    bus.hold = 1'b0;
    wait_done(100);
    idle_chk(2, 0);

    // converged at first check
    b = cyc;
    push(b, 1, 0, 1, 0);
    bus.max_iter = 4'd5;
    bus.syn_ok = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(100);
    bus.syn_ok = 1'b0;
    idle_chk(0, 1);

    // reset while rows 2,3 in flight
    b = cyc;
    for (int r = 0; r < N; r++) rdq.push_back('{b + 1 + r, r, 0});
    wrq.push_back('{b + 5, 0, 0});
    wrq.push_back('{b + 6, 1, 0});
    bus.max_iter = 4'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (8) tick();
    chk("rst_mid_busy", int'(bus.busy), 0);
    chk("rst_mid_wrq", wrq.size(), 0);
    chk("rst_mid_iter", int'(bus.iter), 0);

    // max_iter=0 runs once; start while busy ignored
    b = cyc;
    push(b, 1, 0, 0, 0);
    bus.max_iter = 4'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.max_iter = 4'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(100);
    idle_chk(0, 0);

    chk("rdq_left", rdq.size(), 0);
    chk("wrq_left", wrq.size(), 0);
    chk("dnq_left", dnq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
